// File: rtl/dmux_ctrl_pkg.sv
// Shared control types for the round-robin dispatcher.
// Holds the two-state FSM encoding and the wrap-around index helper.
// Pure declarations; no logic, no latency, no flow control.
package dmux_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // holding register empty
    ST_HOLD = 1'b1   // one word waiting for its consumer
  } state_t;

  // Next consumer index in strict round-robin order, wrapping at n
  function automatic int unsigned next_index(input int unsigned cur, input int unsigned n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/dmux.sv
// Word demultiplexer: copies the input word onto the selected output only.
// Purely combinational, zero latency.
// No flow control; non-selected outputs are driven to zero.
module dmux #(
  parameter int WIDTH   = 32,
  parameter int OUTPUTS = 4
) (
  input  logic [WIDTH-1:0]           in,
  input  logic [$clog2(OUTPUTS)-1:0] sel,
  output logic [WIDTH-1:0]           out [OUTPUTS]
);

  // Steer the word to the selected lane, zero everywhere else
  always_comb begin
    for (int i = 0; i < OUTPUTS; i++) begin
      out[i] = (int'(sel) == i) ? in : '0;
    end
  end

endmodule

// File: rtl/dmux_dispatcher.sv
// Round-robin dispatcher: one holding register fans words out to OUTPUTS consumers in strict order.
// Latency: one cycle from accept to out_valid; one word per cycle when the target is ready.
// Backpressure: waits indefinitely on a non-ready target; accepts only if the held word leaves the same cycle.
module dmux_dispatcher
  import dmux_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OUTPUTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data [OUTPUTS],
  output logic [OUTPUTS-1:0]         out_valid,
  input  logic [OUTPUTS-1:0]         out_ready,
  output logic [$clog2(OUTPUTS)-1:0] target,
  output logic [31:0]                xfer_count
);

  localparam int SELW = $clog2(OUTPUTS);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   target_q, target_d;
  logic [31:0]       xfer_q, xfer_d;
  logic              accept, deliver;

  // Only the current target's ready matters; others are ignored by construction
  assign deliver  = (state_q == ST_HOLD) && out_ready[target_q];
  // Reset gates in_ready so nothing is offered while the block is held in reset
  assign in_ready = rst_n && en && ((state_q == ST_IDLE) || out_ready[target_q]);
  assign accept   = in_valid && in_ready;

  // Next-state: delivery frees the slot and advances the pointer, a same-cycle accept refills it
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    xfer_d   = xfer_q;
    if (deliver) begin
      state_d  = ST_IDLE;
      data_d   = '0;
      target_d = SELW'(next_index(32'(target_q), OUTPUTS));
      xfer_d   = xfer_q + 32'd1;
    end
    if (accept) begin
      state_d = ST_HOLD;
      data_d  = in_data;
    end
  end

  // FSM and datapath registers; reset discards any held word without counting it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      target_q <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      xfer_q   <= xfer_d;
    end
  end

  // Valid one-hot comes straight from state and pointer, independent of the data path
  assign out_valid = (state_q == ST_HOLD) ? (OUTPUTS'(1) << target_q) : '0;

  // The holding register is cleared when empty, so idle lanes read as zero
  dmux #(
    .WIDTH  (WIDTH),
    .OUTPUTS(OUTPUTS)
  ) u_dmux (
    .in (data_q),
    .sel(target_q),
    .out(out_data)
  );

  assign target     = target_q;
  assign xfer_count = xfer_q;

endmodule

// File: doc/dmux_dispatcher.md
DMUX_DISPATCHER -- requirements
Module: dmux_dispatcher

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter OUTPUTS, default 4, number of consumer ports; SHALL support any value from 2 to 16, including non-powers of two.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  dispatch enable; when low, no new word is accepted.
REQ-006 in_data  input  WIDTH  producer word.
REQ-007 in_valid  input  1  producer word valid.
REQ-008 in_ready  output  1  dispatcher can accept a word this cycle.
REQ-009 out_data  output  WIDTH x OUTPUTS (unpacked array)  per-consumer word; non-selected entries are zero.
REQ-010 out_valid  output  OUTPUTS  per-consumer valid, one-hot or zero.
REQ-011 out_ready  input  OUTPUTS  per-consumer ready.
REQ-012 target  output  $clog2(OUTPUTS)  index of the consumer currently held or next to be served.
REQ-013 xfer_count  output  32  number of completed deliveries.

Function
REQ-014 Two-state FSM: IDLE (holding register empty) and HOLD (one word held for delivery).
REQ-015 in_ready SHALL be high when en=1 and either the FSM is in IDLE, or the FSM is in HOLD and out_ready[target]=1.
REQ-016 Accept occurs when in_valid=1 and in_ready=1; on accept, in_data is latched into the holding register and the FSM enters or stays in HOLD.
REQ-017 In HOLD, out_valid[target]=1, out_data[target]=held word, all other out_valid bits are 0 and all other out_data entries are 0.
REQ-018 In IDLE, all out_valid bits are 0 and all out_data entries are 0.
REQ-019 Delivery occurs when the FSM is in HOLD and out_ready[target]=1.
REQ-020 On delivery, target advances to (target+1) mod OUTPUTS, with wrap from OUTPUTS-1 to 0, and xfer_count increments.
REQ-021 On delivery without a simultaneous accept, the FSM returns to IDLE.
REQ-022 Delivery and accept in the same cycle: the FSM stays in HOLD and the new word is presented to the next target in the following cycle.
REQ-023 Latency is one cycle from accept to out_valid; sustained throughput is one word per cycle when consumers are ready.
REQ-024 Strict round-robin: the dispatcher SHALL wait on a non-ready target indefinitely and never skip it.
REQ-025 The held word and target SHALL remain stable while out_ready[target]=0.
REQ-026 out_ready bits of non-target consumers SHALL be ignored.
REQ-027 en=0 blocks accepts only; a word already held is still delivered.
REQ-028 xfer_count wraps from 2^32-1 to 0.

Reset
REQ-029 While rst_n=0, regardless of clk: FSM=IDLE, target=0, xfer_count=0, holding register=0, in_ready=0, all out_valid=0, all out_data=0.
REQ-030 Reset asserted mid-operation SHALL discard the held word with no delivery and no count increment.
REQ-031 The first accept is allowed on the first rising edge after rst_n deasserts, provided en=1.

Structure
REQ-032 The state enum (IDLE, HOLD) SHALL reside in package dmux_ctrl_pkg.
REQ-033 Output steering SHALL use one instance of the existing dmux module (WIDTH, OUTPUTS), with in = held word and sel = target.
REQ-034 The out_valid one-hot SHALL be produced from target and state in a separate assignment, not through the dmux instance.

Verification
REQ-035 OUTPUTS=4, all out_ready=1, en=1, stream words 0xA0..0xA7 back-to-back: deliveries go to ports 0,1,2,3,0,1,2,3 in order; xfer_count=8; in_ready stays high.
REQ-036 OUTPUTS=3, 7 words: target sequence is 0,1,2,0,1,2,0 (non-power-of-two wrap).
REQ-037 Hold 0x55 for port 1 with out_ready[1]=0 for 5 cycles and out_ready[2]=1: out_valid=0b0010, out_data[1]=0x55 stable, in_ready=0, no delivery to port 2.
REQ-038 Drop en while a word is held: that word is still delivered, then in_ready=0 while in_valid=1; raise en and the next accept occurs on that cycle.
REQ-039 Assert rst_n=0 asynchronously mid-HOLD: all outputs zero immediately; after release, target=0 and xfer_count=0.
REQ-040 Preload xfer_count to 0xFFFFFFFF by forcing, then complete 1 delivery: xfer_count=0.
